// File: rtl/seq_pkg.sv
// seq_pkg: shared types and default sizes for the program run sequencer.
package seq_pkg;

   localparam int NUM_PROGS_DEF = 3;
   localparam int CNT_W_DEF     = 16;
   localparam int SLOT_W_DEF    = (NUM_PROGS_DEF > 1) ? $clog2(NUM_PROGS_DEF) : 1;

   // Slot index at the default program count
   typedef logic [SLOT_W_DEF-1:0] slot_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ARM,
      S_RUN,
      S_LOG,
      S_DONE,
      S_ERR
   } seq_state_t;

endpackage

// File: rtl/seq_cycle_counter.sv
// seq_cycle_counter: clearable, enabled, saturating up-counter with a
// terminal-count flag raised while the count equals TC_VAL.
module seq_cycle_counter #(
   parameter int               CNT_W  = 16,
   parameter logic [CNT_W-1:0] TC_VAL = '1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear has priority; counting sticks at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Count register, synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs the core's Start/Ack handshake for each program slot
// in order, records each slot's ARM+RUN cycle count, and flags completion.
// Optional build macro SEQ_TIMEOUT_EN enables the per-slot run-length limit
// (TIMEOUT_CYC) and the ERR state; without it Error/ErrSlot are tied low.
module prog_sequencer
   import seq_pkg::*;
#(
   parameter int          NUM_PROGS   = NUM_PROGS_DEF,
   parameter int          CNT_W       = CNT_W_DEF,
   parameter int          START_CYC   = 1,
   parameter int unsigned TIMEOUT_CYC = 32'hFFF0,
   localparam int         SLOT_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Go,
   input  logic              CoreAck,
   output logic              CoreStart,
   output logic [SLOT_W-1:0] ProgSel,
   output logic              Busy,
   output logic              Done,
   output logic              Error,
   output logic [SLOT_W-1:0] ErrSlot,
   input  logic [SLOT_W-1:0] RdIdx,
   output logic [CNT_W-1:0]  RdCount
);

   localparam int               ST_W    = (START_CYC > 1) ? $clog2(START_CYC + 1) : 1;
   localparam logic [ST_W-1:0]  ST_LAST = ST_W'(START_CYC - 1);
   localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);

   seq_state_t        state_q, state_d;
   logic [SLOT_W-1:0] slot_q;
   logic [ST_W-1:0]   st_cnt_q;
   logic              start_q, busy_q, done_q;
   logic [CNT_W-1:0]  cnt_arr_q [NUM_PROGS];

   logic [CNT_W-1:0]  cnt;
   logic              tc, tmo, last_slot, go_acc, enter_start, to_err, counting;

   assign last_slot   = (slot_q == SLOT_W'(NUM_PROGS - 1));
   assign counting    = (state_q == S_ARM) || (state_q == S_RUN);
   assign go_acc      = Go && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
   assign enter_start = (state_d == S_START) && (state_q != S_START);
   assign to_err      = counting && (state_d == S_ERR);

`ifdef SEQ_TIMEOUT_EN
   assign tmo = tc;
`else
   logic tc_unused;
   assign tc_unused = tc;
   assign tmo       = 1'b0;
`endif

   // Run-length counter: cleared on every new slot, counts ARM and RUN cycles
   seq_cycle_counter #(
      .CNT_W  (CNT_W),
      .TC_VAL (TC_VAL)
   ) u_cnt (
      .clk_i  (Clk),
      .rst_ni (Reset),
      .clr_i  (enter_start),
      .en_i   (counting),
      .cnt_o  (cnt),
      .tc_o   (tc)
   );

   // Next-state: ARM waits out a stale Ack, RUN waits for the new one
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: if (Go) state_d = S_START;
         S_START: if (st_cnt_q == ST_LAST) state_d = S_ARM;
         S_ARM: begin
            if (!CoreAck)  state_d = S_RUN;
            else if (tmo)  state_d = S_ERR;
         end
         S_RUN: begin
            if (CoreAck)   state_d = S_LOG;
            else if (tmo)  state_d = S_ERR;
         end
         S_LOG:   state_d = last_slot ? S_DONE : S_START;
         default: state_d = S_IDLE;
      endcase
   end

   // State, slot, registered outputs and per-slot count storage
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q  <= S_IDLE;
         slot_q   <= '0;
         st_cnt_q <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < NUM_PROGS; i++) cnt_arr_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         start_q  <= (state_d == S_START);
         busy_q   <= (state_d == S_START) || (state_d == S_ARM) ||
                     (state_d == S_RUN)   || (state_d == S_LOG);
         done_q   <= (state_d == S_DONE);
         st_cnt_q <= (state_q == S_START) ? st_cnt_q + ST_W'(1) : '0;

         if (go_acc)
            slot_q <= '0;
         else if ((state_q == S_LOG) && !last_slot)
            slot_q <= slot_q + SLOT_W'(1);

         if (go_acc) begin
            for (int i = 0; i < NUM_PROGS; i++) cnt_arr_q[i] <= '0;
         end else if (state_q == S_LOG) begin
            cnt_arr_q[slot_q] <= cnt;
         end else if (to_err) begin
            cnt_arr_q[slot_q] <= TMO_VAL;
         end
      end
   end

`ifdef SEQ_TIMEOUT_EN
   logic              err_q;
   logic [SLOT_W-1:0] errslot_q;

   // Error flag follows the ERR state; the failing slot is latched on entry
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         err_q     <= 1'b0;
         errslot_q <= '0;
      end else begin
         err_q <= (state_d == S_ERR);
         if (to_err) errslot_q <= slot_q;
      end
   end

   assign Error   = err_q;
   assign ErrSlot = errslot_q;
`else
   assign Error   = 1'b0;
   assign ErrSlot = '0;
`endif

   assign CoreStart = start_q;
   assign ProgSel   = slot_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign RdCount   = (32'(RdIdx) < NUM_PROGS) ? cnt_arr_q[RdIdx] : '0;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed + randomized checks of prog_sequencer against
// a slot-level model: a slot whose Ack stays high s cycles into ARM, then
// low for d cycles, then high, records min(s+d+1, 2^CNT_W-1).
module tb_prog_sequencer;
   import seq_pkg::*;

   localparam int START_CYC = 1;
   localparam int TO        = 32;

   logic        Clk, Reset, Go, CoreAck;
   slot_t       RdIdx;
   logic        CoreStart, Busy, Done, Error;
   slot_t       ProgSel, ErrSlot;
   logic [15:0] RdCount;
   logic        CoreStartS, BusyS, DoneS, ErrorS;
   slot_t       ProgSelS, ErrSlotS;
   logic [3:0]  RdCountS;

   int ntot  = 0;
   int npass = 0;

   prog_sequencer #(.NUM_PROGS(3), .CNT_W(16), .START_CYC(START_CYC), .TIMEOUT_CYC(TO)) dut (
      .Clk(Clk), .Reset(Reset), .Go(Go), .CoreAck(CoreAck), .CoreStart(CoreStart),
      .ProgSel(ProgSel), .Busy(Busy), .Done(Done), .Error(Error), .ErrSlot(ErrSlot),
      .RdIdx(RdIdx), .RdCount(RdCount));

   // Narrow-counter copy sharing the same stimulus, for saturation
   prog_sequencer #(.NUM_PROGS(3), .CNT_W(4), .START_CYC(START_CYC)) dut_sat (
      .Clk(Clk), .Reset(Reset), .Go(Go), .CoreAck(CoreAck), .CoreStart(CoreStartS),
      .ProgSel(ProgSelS), .Busy(BusyS), .Done(DoneS), .Error(ErrorS), .ErrSlot(ErrSlotS),
      .RdIdx(RdIdx), .RdCount(RdCountS));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   function automatic int exp_cnt(input int s, input int d, input int w);
      int raw, sat;
      raw = s + d + 1;
      sat = (1 << w) - 1;
      return (raw > sat) ? sat : raw;
   endfunction

   // Check all stored counts (narrow copy only when no timeout is built in)
   task automatic check_counts(input int e0, input int e1, input int e2,
                               input int f0, input int f1, input int f2);
      int e[3];
      int f[3];
      e = '{e0, e1, e2};
      f = '{f0, f1, f2};
      for (int i = 0; i < 3; i++) begin
         RdIdx = slot_t'(i);
         #1;
         check($sformatf("count%0d", i), RdCount, e[i]);
`ifndef SEQ_TIMEOUT_EN
         check($sformatf("sat_count%0d", i), RdCountS, f[i]);
`endif
      end
   endtask

   // Act as the core for one slot; starts on a negedge, ends on the LOG negedge
   task automatic run_slot(input int slot, input int s, input int d, input bit go_mid);
      int w;
      for (int k = 0; k < 20; k++) begin
         if (CoreStart === 1'b1) break;
         @(negedge Clk);
      end
      check("start_seen", CoreStart, 1);
      check("progsel_start", ProgSel, slot);
      w = 0;
      while (CoreStart === 1'b1 && w < 20) begin
         w++;
         @(negedge Clk);
      end
      check("start_width", w, START_CYC);
      for (int j = 1; j <= s + d + 1; j++) begin
         CoreAck = (j <= s) || (j == s + d + 1);
         Go      = go_mid && (j == 2);
         if (j == 1) check("busy_arm", Busy, 1);
         @(negedge Clk);
      end
      Go = 1'b0;
      check("busy_log", Busy, 1);
      check("progsel_log", ProgSel, slot);
   endtask

   task automatic run_seq(input bit do_go, input int s0, input int s1, input int s2,
                          input int d0, input int d1, input int d2, input int go_slot);
      if (do_go) begin
         Go = 1'b1;
         @(negedge Clk);
         Go = 1'b0;
      end
      run_slot(0, s0, d0, go_slot == 0);
      run_slot(1, s1, d1, go_slot == 1);
      run_slot(2, s2, d2, go_slot == 2);
      @(negedge Clk);
      check("done", Done, 1);
      check("busy_done", Busy, 0);
      check("error_done", Error, 0);
      check_counts(exp_cnt(s0, d0, 16), exp_cnt(s1, d1, 16), exp_cnt(s2, d2, 16),
                   exp_cnt(s0, d0, 4),  exp_cnt(s1, d1, 4),  exp_cnt(s2, d2, 4));
   endtask

   initial begin
      int s[3];
      int d[3];
      int n;
      bit saw;
      Reset = 1'b0; Go = 1'b0; CoreAck = 1'b0; RdIdx = '0;
      repeat (3) @(negedge Clk);

      // Reset state
      check("rst_corestart", CoreStart, 0);
      check("rst_progsel", ProgSel, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_error", Error, 0);
      check("rst_errslot", ErrSlot, 0);
      check_counts(0, 0, 0, 0, 0, 0);
      Reset = 1'b1;
      @(negedge Clk);
      check("idle_busy", Busy, 0);

      // Nominal: Ack 5/10/20 cycles after ARM entry
      run_seq(1'b1, 0, 0, 0, 5, 10, 20, -1);

      // Go in DONE: immediate restart at slot 0, counts cleared
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      check("restart_done", Done, 0);
      check("restart_start", CoreStart, 1);
      check("restart_progsel", ProgSel, 0);
      check_counts(0, 0, 0, 0, 0, 0);
      // Stale Ack carried over from the previous slot
      run_seq(1'b0, 3, 3, 1, 4, 4, 1, -1);

      // Go pulsed mid-run is ignored
      CoreAck = 1'b0;
      run_seq(1'b1, 0, 1, 0, 6, 3, 2, 1);

      // Minimum count 2 on every slot
      run_seq(1'b1, 0, 0, 0, 1, 1, 1, -1);

      // Long slot saturates the narrow copy
      run_seq(1'b1, 0, 0, 0, 29, 1, 2, -1);

      // Randomized slot timing
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 3; i++) begin
            s[i] = int'($urandom_range(0, 3));
            d[i] = int'($urandom_range(1, 10));
         end
         run_seq(1'b1, s[0], s[1], s[2], d[0], d[1], d[2], int'($urandom_range(0, 3)));
      end

      // Reset mid-RUN of slot 1
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      run_slot(0, 0, 3, 1'b0);
      for (int k = 0; k < 20 && CoreStart !== 1'b1; k++) @(negedge Clk);
      for (int k = 0; k < 20 && CoreStart === 1'b1; k++) @(negedge Clk);
      CoreAck = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("midrst_corestart", CoreStart, 0);
      check("midrst_progsel", ProgSel, 0);
      check("midrst_busy", Busy, 0);
      check("midrst_done", Done, 0);
      check("midrst_error", Error, 0);
      check_counts(0, 0, 0, 0, 0, 0);
      Reset = 1'b1;
      @(negedge Clk);
      run_seq(1'b1, 0, 2, 0, 2, 3, 4, -1);

`ifdef SEQ_TIMEOUT_EN
      // Slot 1 never acks: ERR after TO counted cycles, slot 2 never started
      CoreAck = 1'b0;
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      run_slot(0, 0, 3, 1'b0);
      for (int k = 0; k < 20 && CoreStart !== 1'b1; k++) @(negedge Clk);
      check("to_progsel", ProgSel, 1);
      for (int k = 0; k < 20 && CoreStart === 1'b1; k++) @(negedge Clk);
      CoreAck = 1'b0;
      n = 0;
      saw = 1'b0;
      while (Error !== 1'b1 && n < 100) begin
         @(negedge Clk);
         n++;
         if (CoreStart === 1'b1) saw = 1'b1;
      end
      check("to_cycles", n, TO);
      check("to_error", Error, 1);
      check("to_errslot", ErrSlot, 1);
      check("to_busy", Busy, 0);
      repeat (10) begin
         @(negedge Clk);
         if (CoreStart === 1'b1) saw = 1'b1;
      end
      check("to_no_start", saw, 0);
      check_counts(4, TO, 0, 0, 0, 0);
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Hardware run controller in front of `TopLevel`. It drives the core's `Start`/`Ack` handshake for each program slot in order (P1, P2, P3), measures each program's run length in clock cycles, and reports completion or timeout. It lets a bench or a top-level wrapper launch all programs with a single `Go` pulse instead of hand-timed `Start` pulses.

## Interface
Parameters:
- `NUM_PROGS`, 3: number of program slots run per sequence.
- `CNT_W`, 16: width of the cycle counter and of each stored count.
- `START_CYC`, 1: number of cycles `CoreStart` is held high per program.
- `TIMEOUT_CYC`, 16'hFFF0: run-length limit per program (used only with `SEQ_TIMEOUT_EN`).

Ports:
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `Go`  in  1  sampled high in IDLE or DONE/ERR → start a sequence at slot 0.
- `CoreAck`  in  1  core's `Ack` (level, done flag).
- `CoreStart`  out  1  to core `Start`.
- `ProgSel`  out  $clog2(NUM_PROGS)  current slot index, stable from START through LOG.
- `Busy`  out  1  high in START/ARM/RUN/LOG.
- `Done`  out  1  high in DONE.
- `Error`  out  1  high in ERR.
- `ErrSlot`  out  $clog2(NUM_PROGS)  slot that timed out.
- `RdIdx`  in  $clog2(NUM_PROGS)  count readout select.
- `RdCount`  out  CNT_W  stored count of slot `RdIdx` (combinational read).

## Operation
- States: IDLE, START, ARM, RUN, LOG, DONE, ERR.
- IDLE: `Go`=1 → START, slot←0, counter←0, all stored counts←0.
- START: `CoreStart`=1 for exactly START_CYC cycles, then → ARM.
- ARM: waits for `CoreAck`=0. This guards against a stale `Ack` left high by the previous program. `CoreAck`=0 → RUN.
- RUN: waits for `CoreAck`=1 → LOG.
- The counter increments every cycle spent in ARM and RUN, including the cycle in which `CoreAck`=1 is sampled. It saturates at 2^CNT_W−1.
- LOG: one cycle; the counter value is written to the slot's count register. If slot==NUM_PROGS−1 → DONE; else slot+1, counter←0, → START.
- DONE: `Done`=1 and holds. `Go`=1 → restart, same as from IDLE.
- ERR: see Configuration. `CoreStart`=0. `Go`=1 → restart, same as from IDLE.
- `Go` is ignored in START/ARM/RUN/LOG.
- A `CoreAck` pulse during START is ignored.

## Timing
- Reset values (`Reset`=0 at an edge): state IDLE, `CoreStart`=0, `ProgSel`=0, `Busy`=0, `Done`=0, `Error`=0, `ErrSlot`=0, all counts 0, counter 0.
- Reset wins over every other event, including mid-RUN. The core is not restarted by this block.
- `Go` sampled at edge N → `CoreStart`=1 and `ProgSel`=0 from N+1 through N+START_CYC.
- Minimum per-program overhead is START_CYC+1 (LOG) cycles beyond the counted ARM/RUN cycles.
- Minimum count is 2: one ARM cycle with `Ack` low, then `Ack` high on the next cycle.
- All outputs are registered except `RdCount`.

## Configuration
- `SEQ_TIMEOUT_EN` defined: in ARM or RUN, if the counter equals TIMEOUT_CYC−1 and `CoreAck` does not complete the state that cycle, then:
  - next state is ERR, `ErrSlot`←slot;
  - the count register for that slot is written with TIMEOUT_CYC;
  - remaining slots are not run.
- `SEQ_TIMEOUT_EN` undefined: no timeout, the ERR state is unreachable, `Error` and `ErrSlot` are tied to 0, and TIMEOUT_CYC is unused.

## Structure
- Package `seq_pkg`:
  - state enum `seq_state_t`;
  - default constants for NUM_PROGS and CNT_W;
  - slot index type `slot_t`.
- Sub-module `seq_cycle_counter`: clear, enable and saturate, CNT_W wide, with a terminal-count compare output used for the timeout.
- Count storage is a NUM_PROGS×CNT_W register array inside `prog_sequencer`.

## Test plan
- Nominal: core model raises `Ack` 5, 10 and 20 cycles after entering ARM, with `Ack` low at ARM entry → `Done`=1; `RdCount` for slots 0/1/2 = 6, 11, 21; `CoreStart` pulses are START_CYC wide with `ProgSel` = 0, 1, 2.
- Stale Ack: `Ack` held high from the previous slot until 3 cycles into ARM, then low, then high 4 cycles later → ARM dwell of 3 cycles; slot count = 3+1+4 = 8; no early advance.
- Timeout (`SEQ_TIMEOUT_EN`, TIMEOUT_CYC=32): slot 1 never acks → `Error`=1, `ErrSlot`=1, slot 1 count 32, slot 2 count 0, `CoreStart` never asserted for slot 2.
- Reset mid-RUN of slot 1 → next cycle all outputs at reset values; a new `Go` restarts at slot 0 with all counts cleared.
- `Go` pulsed during RUN → ignored, sequence unaffected. `Go` in DONE → `Done` drops and slot 0 restarts the next cycle.
- Saturation (CNT_W=4, timeout off): `Ack` after 30 cycles → stored count 15.
